// File: rtl/uart_tx_fifo_if.sv
// Byte-in / serial-out bundle between a byte source and the buffered UART
// transmitter. The master side queues bytes; the slave side is the transmitter.
interface uart_tx_fifo_if;
  logic       new_data;
  logic [7:0] char;
  logic       full;
  logic       empty;
  logic       busy;
  logic       overflow;
  logic       out_bit;

  modport master (
    output new_data, char,
    input  full, empty, busy, overflow, out_bit
  );

  modport slave (
    input  new_data, char,
    output full, empty, busy, overflow, out_bit
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter. Bytes are queued in a FIFO and serialised
// LSB-first with back-to-back frames: when the stop bit ends and another byte
// is waiting, the next start bit follows with no idle cycle in between.
module uart_tx_fifo #(
  parameter int CLK_HZ     = 16000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  uart_tx_fifo_if.slave bus
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int PTR_W        = $clog2(FIFO_DEPTH);
  localparam int CNT_W        = PTR_W + 1;
  localparam int BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // FIFO storage and bookkeeping
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             wr_en;
  logic             pop;
  logic             overflow_q;

  // Transmit FSM
  state_t            state;
  state_t            state_next;
  logic [BAUD_W-1:0] baud_cnt;
  logic [BAUD_W-1:0] baud_next;
  logic [2:0]        bit_cnt;
  logic [2:0]        bit_next;
  logic [7:0]        shift;
  logic [7:0]        shift_next;
  logic              out_q;
  logic              out_next;

  // full/empty come from the registered count, so they never depend on this
  // cycle's strobe; a write arriving while full is dropped even if a pop
  // frees a slot in the same cycle.
  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);
  assign wr_en = bus.new_data && !full;

  // Queue the incoming byte; storage needs no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= bus.char;
    end
  end

  // Pointers, occupancy and the one-cycle dropped-write flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= bus.new_data && full;
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({wr_en, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Next-state logic: bit timing, shifting and FIFO pops.
  always_comb begin
    state_next = state;
    baud_next  = baud_cnt;
    bit_next   = bit_cnt;
    shift_next = shift;
    pop        = 1'b0;
    unique case (state)
      IDLE: begin
        baud_next = '0;
        bit_next  = '0;
        if (!empty) begin
          pop        = 1'b1;
          shift_next = mem[rd_ptr];
          state_next = START;
        end
      end
      START: begin
        if (baud_cnt == BAUD_LAST) begin
          baud_next  = '0;
          state_next = DATA;
        end else begin
          baud_next = baud_cnt + BAUD_W'(1);
        end
      end
      DATA: begin
        if (baud_cnt == BAUD_LAST) begin
          baud_next  = '0;
          shift_next = {1'b0, shift[7:1]};
          if (bit_cnt == 3'd7) begin
            bit_next   = '0;
            state_next = STOP;
          end else begin
            bit_next = bit_cnt + 3'd1;
          end
        end else begin
          baud_next = baud_cnt + BAUD_W'(1);
        end
      end
      STOP: begin
        if (baud_cnt == BAUD_LAST) begin
          baud_next = '0;
          if (!empty) begin
            pop        = 1'b1;
            shift_next = mem[rd_ptr];
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end else begin
          baud_next = baud_cnt + BAUD_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Line level for the coming cycle, derived from where the FSM is heading so
  // the registered out_bit switches on the same edge as the state.
  always_comb begin
    out_next = 1'b1;
    case (state_next)
      START:   out_next = 1'b0;
      DATA:    out_next = shift_next[0];
      default: out_next = 1'b1;
    endcase
  end

  // FSM control registers; reset aborts any frame and returns the line high.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      out_q    <= 1'b1;
    end else begin
      state    <= state_next;
      baud_cnt <= baud_next;
      bit_cnt  <= bit_next;
      out_q    <= out_next;
    end
  end

  // Shift register holds payload only, so it is left out of reset.
  always_ff @(posedge clk) begin
    shift <= shift_next;
  end

  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.busy     = (state != IDLE);
  assign bus.overflow = overflow_q;
  assign bus.out_bit  = out_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with CLKS_PER_BIT = 4: a 16-deep instance
// for frame timing, back-to-back frames, overflow and reset, plus a 4-deep
// instance for pointer wrap under paced writes.
module tb_uart_tx_fifo;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mon_en = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  uart_tx_fifo_if ifc ();
  uart_tx_fifo_if ifc4 ();

  uart_tx_fifo #(.CLK_HZ(16), .BAUD(4), .FIFO_DEPTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  uart_tx_fifo #(.CLK_HZ(16), .BAUD(4), .FIFO_DEPTH(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (ifc4.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at the negedge of the first start-bit cycle; walks all 40 cycles.
  task automatic check_frame(input string tag, input logic [7:0] b);
    logic [9:0] bits;
    logic [7:0] got;
    int bad;
    bits = {1'b1, b, 1'b0};
    got  = 8'h00;
    bad  = 0;
    for (int i = 0; i < 40; i++) begin
      if (i > 0) @(negedge clk);
      if (ifc.out_bit !== bits[i / 4] || ifc.busy !== 1'b1) bad++;
      if (i / 4 >= 1 && i / 4 <= 8 && i % 4 == 2) got[i / 4 - 1] = ifc.out_bit;
    end
    chk({tag, "_byte"}, 32'(got), 32'(b));
    chk({tag, "_shape"}, bad, 0);
  endtask

  // Serial decoder for the 4-deep instance.
  logic [7:0] rx4[$];
  int stop_err4 = 0;
  int ovf4 = 0;

  initial begin : rx4_mon
    logic [7:0] b;
    wait (mon_en);
    forever begin
      @(negedge clk);
      if (ifc4.out_bit == 1'b0) begin
        repeat (2) @(negedge clk);
        for (int j = 0; j < 8; j++) begin
          repeat (4) @(negedge clk);
          b[j] = ifc4.out_bit;
        end
        repeat (4) @(negedge clk);
        if (ifc4.out_bit != 1'b1) stop_err4++;
        @(negedge clk);
        rx4.push_back(b);
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en && ifc4.overflow) ovf4++;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [7:0] exp6[$];
    int budget;

    ifc.new_data  = 1'b0;
    ifc.char      = 8'h00;
    ifc4.new_data = 1'b0;
    ifc4.char     = 8'h00;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_bit", ifc.out_bit, 1);
    chk("rst_empty", ifc.empty, 1);
    chk("rst_full", ifc.full, 0);
    chk("rst_busy", ifc.busy, 0);
    chk("rst_overflow", ifc.overflow, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;
    repeat (2) @(posedge clk); #1;

    // Test 1: single byte 0x55, latency and frame shape
    ifc.new_data = 1'b1;
    ifc.char     = 8'h55;
    @(negedge clk);
    chk("t1_empty_n", ifc.empty, 1);
    @(posedge clk); #1;
    ifc.new_data = 1'b0;
    ifc.char     = 8'hFF;
    @(negedge clk);
    chk("t1_empty_n1", ifc.empty, 0);
    chk("t1_line_n1", ifc.out_bit, 1);
    chk("t1_busy_n1", ifc.busy, 0);
    @(negedge clk);
    check_frame("t1", 8'h55);
    @(negedge clk);
    chk("t1_busy_end", ifc.busy, 0);
    chk("t1_empty_end", ifc.empty, 1);
    chk("t1_line_end", ifc.out_bit, 1);

    // Test 2: three consecutive writes, contiguous frames
    @(posedge clk); #1;
    fork
      begin
        ifc.new_data = 1'b1;
        ifc.char = 8'h41; @(posedge clk); #1;
        ifc.char = 8'h42; @(posedge clk); #1;
        ifc.char = 8'h43; @(posedge clk); #1;
        ifc.new_data = 1'b0;
      end
      begin
        repeat (3) @(negedge clk);
        check_frame("t2_f0", 8'h41);
        @(negedge clk);
        check_frame("t2_f1", 8'h42);
        @(negedge clk);
        check_frame("t2_f2", 8'h43);
      end
    join
    @(negedge clk);
    chk("t2_busy_end", ifc.busy, 0);
    chk("t2_empty_end", ifc.empty, 1);

    // Test 3: 18 writes, last one dropped while full
    @(posedge clk); #1;
    fork
      begin
        for (int i = 0; i < 18; i++) begin
          ifc.new_data = 1'b1;
          ifc.char     = 8'(i);
          @(posedge clk); #1;
        end
        ifc.new_data = 1'b0;
      end
      begin
        repeat (17) @(negedge clk);
        chk("t3_full_n16", ifc.full, 0);
        @(negedge clk);
        chk("t3_full_n17", ifc.full, 1);
        chk("t3_ovf_n17", ifc.overflow, 0);
        @(negedge clk);
        chk("t3_ovf_n18", ifc.overflow, 1);
        @(negedge clk);
        chk("t3_ovf_n19", ifc.overflow, 0);
      end
      begin
        repeat (3) @(negedge clk);
        for (int i = 0; i < 17; i++) begin
          if (i > 0) @(negedge clk);
          check_frame($sformatf("t3_f%0d", i), 8'(i));
        end
      end
    join
    @(negedge clk);
    chk("t3_busy_end", ifc.busy, 0);
    chk("t3_empty_end", ifc.empty, 1);

    // Test 4: reset in the middle of 0xA5's data bits with 3 bytes queued
    @(posedge clk); #1;
    fork
      begin
        ifc.new_data = 1'b1;
        ifc.char = 8'hA5; @(posedge clk); #1;
        ifc.char = 8'h01; @(posedge clk); #1;
        ifc.char = 8'h02; @(posedge clk); #1;
        ifc.char = 8'h03; @(posedge clk); #1;
        ifc.new_data = 1'b0;
      end
      begin
        repeat (10) @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("t4_line_pre", ifc.out_bit, 0);
        chk("t4_busy_pre", ifc.busy, 1);
        chk("t4_empty_pre", ifc.empty, 0);
        @(posedge clk); #1;
        rst = 1'b0;
      end
    join
    @(negedge clk);
    chk("t4_line_post", ifc.out_bit, 1);
    chk("t4_empty_post", ifc.empty, 1);
    chk("t4_busy_post", ifc.busy, 0);
    begin
      int lows;
      lows = 0;
      for (int i = 0; i < 60; i++) begin
        @(negedge clk);
        if (ifc.out_bit !== 1'b1 || ifc.busy !== 1'b0) lows++;
      end
      chk("t4_quiet", lows, 0);
    end

    // Test 5: write while full in the same cycle the FSM pops
    @(posedge clk); #1;
    fork
      begin
        for (int i = 0; i < 17; i++) begin
          ifc.new_data = 1'b1;
          ifc.char     = 8'(8'h20 + i);
          @(posedge clk); #1;
        end
        ifc.new_data = 1'b0;
        repeat (24) @(posedge clk); #1;
        ifc.new_data = 1'b1;
        ifc.char     = 8'h77;
        @(posedge clk); #1;
        ifc.char     = 8'h99;
        @(posedge clk); #1;
        ifc.new_data = 1'b0;
      end
      begin
        repeat (42) @(negedge clk);
        chk("t5_full_pop", ifc.full, 1);
        chk("t5_ovf_pop", ifc.overflow, 0);
        @(negedge clk);
        chk("t5_full_after", ifc.full, 0);
        chk("t5_ovf_after", ifc.overflow, 1);
        @(negedge clk);
        chk("t5_full_refill", ifc.full, 1);
        chk("t5_ovf_refill", ifc.overflow, 0);
      end
      begin
        repeat (3) @(negedge clk);
        for (int i = 0; i < 17; i++) begin
          if (i > 0) @(negedge clk);
          check_frame($sformatf("t5_f%0d", i), 8'(8'h20 + i));
        end
        @(negedge clk);
        check_frame("t5_f17", 8'h99);
      end
    join
    @(negedge clk);
    chk("t5_busy_end", ifc.busy, 0);
    chk("t5_empty_end", ifc.empty, 1);

    // Test 6: depth-4 instance, 40 paced writes across many pointer wraps
    @(posedge clk); #1;
    for (int i = 0; i < 40; i++) begin
      budget = 0;
      while (ifc4.full && budget < 200) begin
        @(posedge clk); #1;
        budget++;
      end
      if (budget >= 200) chk("t6_full_stuck", 1, 0);
      exp6.push_back(8'(i * 37 + 11));
      ifc4.char     = 8'(i * 37 + 11);
      ifc4.new_data = 1'b1;
      @(posedge clk); #1;
      ifc4.new_data = 1'b0;
      repeat (i % 3) begin
        @(posedge clk); #1;
      end
    end
    budget = 0;
    while (rx4.size() < 40 && budget < 3000) begin
      @(posedge clk); #1;
      budget++;
    end
    chk("t6_rx_count", rx4.size(), 40);
    for (int i = 0; i < 40 && i < rx4.size(); i++) begin
      chk($sformatf("t6_b%0d", i), 32'(rx4[i]), 32'(exp6[i]));
    end
    chk("t6_stop_err", stop_err4, 0);
    chk("t6_overflow", ovf4, 0);
    @(negedge clk);
    chk("t6_empty_end", ifc4.empty, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
